// File: rtl/sound_sequencer.sv
// Sound effect sequencer: latches eat/crash/win requests, arbitrates by fixed
// priority and plays each effect as a timed note sequence on one tone oscillator.
module sound_sequencer #(
  parameter int NOTE_TICKS = 4,
  parameter int GAP_TICKS  = 1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       en,
  input  logic       tick,
  input  logic       req_eat,
  input  logic       req_crash,
  input  logic       req_win,
  output logic [7:0] freq,
  output logic       playSound,
  output logic       busy,
  output logic [1:0] cur_id,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int CNT_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : '0;

  state_t        state;
  logic [2:0]    pend;
  logic [1:0]    note_idx;
  logic [CW-1:0] tick_cnt;

  logic [2:0] req_vec;
  logic [2:0] clr_mask;
  logic [1:0] top_id;
  logic       load_now;
  logic       last_note;
  logic [7:0] next_freq;

  function automatic logic [7:0] note_freq(input logic [1:0] id, input logic [1:0] idx);
    logic [7:0] f;
    case ({id, idx})
      4'b01_00: f = 8'd40;
      4'b01_01: f = 8'd30;
      4'b10_00: f = 8'd120;
      4'b10_01: f = 8'd160;
      4'b10_10: f = 8'd200;
      4'b10_11: f = 8'd240;
      4'b11_00: f = 8'd60;
      4'b11_01: f = 8'd50;
      4'b11_10: f = 8'd40;
      4'b11_11: f = 8'd30;
      default:  f = 8'd0;
    endcase
    return f;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] id);
    logic [1:0] l;
    case (id)
      2'd1:    l = 2'd1;
      2'd2:    l = 2'd3;
      2'd3:    l = 2'd3;
      default: l = 2'd0;
    endcase
    return l;
  endfunction

  // pend bit n holds request id n+1
  assign req_vec   = {req_win, req_crash, req_eat};
  assign state_dbg = state;
  assign last_note = (note_idx == last_idx(cur_id));
  assign next_freq = note_freq(cur_id, note_idx + 2'd1);

  always_comb begin
    top_id = 2'd0;
    if (pend[2])      top_id = 2'd3;
    else if (pend[1]) top_id = 2'd2;
    else if (pend[0]) top_id = 2'd1;
  end

  // A new load starts from IDLE, or preempts a running sequence of lower id.
  always_comb begin
    load_now = 1'b0;
    case (state)
      IDLE:      load_now = (top_id != 2'd0);
      PLAY, GAP: load_now = (top_id > cur_id);
      default:   load_now = 1'b0;
    endcase
  end

  always_comb begin
    clr_mask = 3'b000;
    case ({load_now, top_id})
      3'b1_01: clr_mask = 3'b001;
      3'b1_10: clr_mask = 3'b010;
      3'b1_11: clr_mask = 3'b100;
      default: clr_mask = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      pend      <= 3'b000;
      note_idx  <= 2'd0;
      tick_cnt  <= '0;
      freq      <= 8'd0;
      playSound <= 1'b0;
      busy      <= 1'b0;
      cur_id    <= 2'd0;
    end else if (!en) begin
      state     <= IDLE;
      pend      <= 3'b000;
      note_idx  <= 2'd0;
      tick_cnt  <= '0;
      freq      <= 8'd0;
      playSound <= 1'b0;
      busy      <= 1'b0;
      cur_id    <= 2'd0;
    end else begin
      // A request arriving on the clearing cycle survives the clear.
      pend <= (pend & ~clr_mask) | req_vec;
      if (load_now) begin
        state     <= LOAD;
        cur_id    <= top_id;
        note_idx  <= 2'd0;
        tick_cnt  <= '0;
        freq      <= note_freq(top_id, 2'd0);
        playSound <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          LOAD: begin
            state     <= PLAY;
            playSound <= 1'b1;
          end
          PLAY: begin
            if (tick) begin
              if (tick_cnt == NOTE_LAST) begin
                tick_cnt <= '0;
                if (GAP_TICKS == 0) begin
                  if (last_note) begin
                    state     <= IDLE;
                    cur_id    <= 2'd0;
                    freq      <= 8'd0;
                    note_idx  <= 2'd0;
                    playSound <= 1'b0;
                    busy      <= 1'b0;
                  end else begin
                    note_idx  <= note_idx + 2'd1;
                    freq      <= next_freq;
                    playSound <= 1'b1;
                  end
                end else begin
                  state     <= GAP;
                  playSound <= 1'b0;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          GAP: begin
            if (tick) begin
              if (tick_cnt == GAP_LAST) begin
                tick_cnt <= '0;
                if (last_note) begin
                  state     <= IDLE;
                  cur_id    <= 2'd0;
                  freq      <= 8'd0;
                  note_idx  <= 2'd0;
                  playSound <= 1'b0;
                  busy      <= 1'b0;
                end else begin
                  state     <= PLAY;
                  note_idx  <= note_idx + 2'd1;
                  freq      <= next_freq;
                  playSound <= 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
